// File: rtl/uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl
//   Receive-side sequencer for the UART RX datapath. It synchronizes the
//   serial line and detects and validates the start bit using OVERSAMPLE
//   clocks per bit. It drives mid-bit strobes for the external shift
//   register, parity checker and stop-bit detector. At the end of each frame
//   it captures the word and its error flags into a one-entry holding
//   register, which the consumer drains through a valid/ready handshake.
//
// Ports
//   rx_clk, rx_rst_n     : clock, synchronous active-low reset
//   rx_in                : raw asynchronous serial line (idle = 1)
//   parallel_in          : assembled word from the external sipo
//   parity_bit_error     : parity checker result (cycle after parity_load)
//   stop_bit_error       : stop-bit detector result (cycle after check_stop)
//   rx_sync              : synchronized serial line for the datapath
//   shift / parity_load / check_stop : one-cycle mid-bit strobes
//   busy                 : a frame is in progress (any state but IDLE)
//   rx_data, rx_valid, rx_ready            : holding register handshake
//   rx_parity_err, rx_frame_err, rx_overrun : flags for the held word
// ----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module uart_rx_ctrl #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst_n,
    input  logic                  rx_in,
    input  logic [DATA_WIDTH-1:0] parallel_in,
    input  logic                  parity_bit_error,
    input  logic                  stop_bit_error,
    output logic                  rx_sync,
    output logic                  shift,
    output logic                  parity_load,
    output logic                  check_stop,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err,
    output logic                  rx_overrun
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_WIDTH + 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_LOAD
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_sync_prev;
    logic [OS_W-1:0]       r_os_cnt;
    logic [BC_W-1:0]       r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_parity_err;
    logic                  r_frame_err;
    logic                  r_overrun;
    logic                  w_fall;
    logic                  w_os_mid;
    logic                  w_os_last;
    logic                  w_xfer;
    logic                  w_slot_free;

    // Line synchronizer plus one history flop for falling-edge detection.
    // Resetting to 1 (idle) keeps reset release from looking like a start bit.
    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop take its
            // pre-edge value; blocking ones would collapse the chain into one.
            r_sync1     <= rx_in;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    // Only a 1->0 transition starts a frame, so a line stuck low (a break,
    // or a framing error) must go back high before it can start another.
    assign w_fall    = r_sync_prev & ~r_sync2;
    assign w_os_mid  = (r_os_cnt == OS_MID);
    assign w_os_last = (r_os_cnt == OS_LAST);

    // State register
    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: the default assignment comes first so every path drives
        // w_state_next and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_fall) w_state_next = S_START;
            S_START:  if (w_os_mid) w_state_next = r_sync2 ? S_IDLE : S_DATA;
            S_DATA:   if (w_os_last && (r_bit_cnt == BC_LAST))
                          w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_os_last) w_state_next = S_STOP;
            S_STOP:   if (w_os_last) w_state_next = S_LOAD;
            S_LOAD:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Output logic. The strobes are gated by reset, so a strobe that would
    // land on the reset cycle is suppressed.
    always_comb begin
        shift       = 1'b0;
        parity_load = 1'b0;
        check_stop  = 1'b0;
        if (rx_rst_n) begin
            case (r_state)
                S_DATA:   shift       = w_os_last;
                S_PARITY: parity_load = w_os_last;
                S_STOP:   check_stop  = w_os_last;
                default:  ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);

    // Oversample counter restarts on every state entry and wraps at each
    // bit boundary. This puts every strobe a whole bit period after the
    // start-bit mid-point.
    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            r_os_cnt  <= '0;
            r_bit_cnt <= '0;
        end else begin
            if ((w_state_next != r_state) || w_os_last || (r_state == S_IDLE)) begin
                r_os_cnt <= '0;
            end else begin
                r_os_cnt <= r_os_cnt + OS_W'(1);
            end
            if (r_state == S_START) begin
                r_bit_cnt <= '0;
            end else if (shift) begin
                r_bit_cnt <= r_bit_cnt + BC_W'(1);
            end
        end
    end

    // Holding register. A transfer in the LOAD cycle frees the slot, so the
    // new word replaces the old one without a bubble and without overrun.
    assign w_xfer      = r_valid & rx_ready;
    assign w_slot_free = ~r_valid | w_xfer;

    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            // NOTE: the data register is reset as well as the control flags,
            // so rx_data reads 0 before the first frame. It is a single
            // register, not a memory array.
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (r_state == S_LOAD) begin
            if (w_slot_free) begin
                r_data       <= parallel_in;
                r_parity_err <= (PARITY_EN != 0) && parity_bit_error;
                r_frame_err  <= stop_bit_error;
                r_valid      <= 1'b1;
                if (w_xfer) r_overrun <= 1'b0;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (w_xfer) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign rx_sync       = r_sync2;
    assign rx_data       = r_data;
    assign rx_valid      = r_valid;
    assign rx_parity_err = r_parity_err;
    assign rx_frame_err  = r_frame_err;
    assign rx_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_ctrl
//   Bench for uart_rx_ctrl. It contains simple behavioural stand-ins for
//   the sipo, the parity checker and the stop-bit detector. It drives
//   serial frames and checks against expectations built from the frame
//   contents and the documented strobe timing.
// ----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rx_rst_n;
    logic       rx_in;
    logic       rx_ready;
    logic       rx_sync, shift, parity_load, check_stop, busy;
    logic [7:0] rx_data;
    logic       rx_valid, rx_parity_err, rx_frame_err, rx_overrun;

    // Datapath stand-ins
    logic [7:0] sipo_q     = '0;
    logic       par_err_q  = 1'b0;
    logic       stop_err_q = 1'b0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(1)) dut (
        .rx_clk(clk), .rx_rst_n(rx_rst_n), .rx_in(rx_in),
        .parallel_in(sipo_q), .parity_bit_error(par_err_q),
        .stop_bit_error(stop_err_q), .rx_sync(rx_sync), .shift(shift),
        .parity_load(parity_load), .check_stop(check_stop), .busy(busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
        .rx_overrun(rx_overrun)
    );

    // LSB-first shift register, even-parity checker, stop detector
    always @(posedge clk) begin
        if (shift)       sipo_q     <= {rx_sync, sipo_q[7:1]};
        if (parity_load) par_err_q  <= (^sipo_q) ^ rx_sync;
        if (check_stop)  stop_err_q <= ~rx_sync;
    end

    // Cycle counter and event monitor (sampled on the falling edge)
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int t_fall, busy_rise, busy_fall, valid_t, overlap = 0;
    int shift_q[$];
    int pl_q[$];
    int cs_q[$];
    logic prev_sync = 1'b1, prev_busy = 1'b0, prev_valid = 1'b0;

    always @(negedge clk) begin
        if (t_fall < 0 && prev_sync && !rx_sync) t_fall = cyc;
        if (busy_rise < 0 && busy && !prev_busy) busy_rise = cyc;
        if (busy_fall < 0 && busy_rise >= 0 && !busy && prev_busy) busy_fall = cyc;
        if (valid_t < 0 && rx_valid && !prev_valid) valid_t = cyc;
        if (shift) shift_q.push_back(cyc);
        if (parity_load) pl_q.push_back(cyc);
        if (check_stop) cs_q.push_back(cyc);
        if ((int'(shift) + int'(parity_load) + int'(check_stop)) > 1) overlap++;
        prev_sync  = rx_sync;
        prev_busy  = busy;
        prev_valid = rx_valid;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        t_fall = -1; busy_rise = -1; busy_fall = -1; valid_t = -1;
        shift_q.delete(); pl_q.delete(); cs_q.delete();
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (OS) tick();
    endtask

    // Start, 8 data bits LSB first, even parity (optionally inverted), stop.
    task automatic send_frame(input logic [7:0] d, input bit pbad, input bit sbad);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((^d) ^ pbad);
        send_bit(!sbad);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!rx_valid && n < 300) begin
            tick();
            n++;
        end
        check(name, rx_valid, 1);
    endtask

    task automatic pulse_ready();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         pbad;
        bit         sbad;
        bit         timing;
        logic [7:0] exp_data;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        bit         pe;
        bit         fe;
    } exp_t;

    exp_t exp_q[$];
    bit   send_done;
    int   n_extra;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1};
        vecs[5] = '{8'h80, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0};

        mon_clear();
        rx_rst_n = 1'b0;
        rx_in    = 1'b1;
        rx_ready = 1'b0;
        repeat (3) tick();
        check("rst_sync", rx_sync, 1);
        check("rst_busy", busy, 0);
        check("rst_strobes", {shift, parity_load, check_stop}, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 0);
        rx_rst_n = 1'b1;
        repeat (3) tick();

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            mon_clear();
            send_frame(vecs[i].data, vecs[i].pbad, vecs[i].sbad);
            wait_valid($sformatf("vec%0d_valid", i));
            check($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
            check($sformatf("vec%0d_perr", i), rx_parity_err, vecs[i].exp_perr);
            check($sformatf("vec%0d_ferr", i), rx_frame_err, vecs[i].exp_ferr);
            check($sformatf("vec%0d_ovr", i), rx_overrun, 0);
            if (vecs[i].timing) begin
                check("t_found", t_fall >= 0, 1);
                check("shift_count", shift_q.size(), 8);
                for (int k = 0; k < shift_q.size(); k++)
                    check($sformatf("shift%0d_time", k + 1), shift_q[k] - t_fall, 24 + 16 * k);
                check("pload_time", pl_q.size() == 1 ? pl_q[0] - t_fall : -1, 152);
                check("cstop_time", cs_q.size() == 1 ? cs_q[0] - t_fall : -1, 168);
                check("valid_time", valid_t - t_fall, 170);
                check("busy_rise", busy_rise - t_fall, 1);
                check("busy_fall", busy_fall - t_fall, 170);
            end
            pulse_ready();
            check($sformatf("vec%0d_cleared", i), rx_valid, 0);
            if (vecs[i].sbad) begin
                // Line held low after a framing error must not retrigger
                mon_clear();
                repeat (200) tick();
                check($sformatf("vec%0d_low_busy", i), busy_rise, -1);
                check($sformatf("vec%0d_low_shift", i), shift_q.size(), 0);
                check($sformatf("vec%0d_low_valid", i), rx_valid, 0);
                rx_in = 1'b1;
                repeat (20) tick();
            end
        end

        // Glitch: 5 low cycles is a false start
        mon_clear();
        rx_in = 1'b0;
        repeat (5) tick();
        rx_in = 1'b1;
        repeat (15) tick();
        check("glitch_started", busy_rise - t_fall, 1);
        check("glitch_busy_fall", busy_fall - t_fall, 9);
        check("glitch_shift", shift_q.size(), 0);
        check("glitch_busy", busy, 0);
        check("glitch_valid", rx_valid, 0);

        // Overrun: two frames with no consumer
        send_frame(8'h11, 1'b0, 1'b0);
        wait_valid("ovr_first_valid");
        send_frame(8'h22, 1'b0, 1'b0);
        repeat (4) tick();
        check("ovr_data_kept", rx_data, 8'h11);
        check("ovr_flag", rx_overrun, 1);
        check("ovr_valid", rx_valid, 1);
        pulse_ready();
        check("ovr_valid_clr", rx_valid, 0);
        check("ovr_flag_clr", rx_overrun, 0);
        repeat (5) tick();

        // Transfer in the same cycle as LOAD: t = start + 2, LOAD = t + 169
        send_frame(8'h44, 1'b0, 1'b0);
        wait_valid("same_cyc_first");
        fork
            send_frame(8'h55, 1'b0, 1'b0);
            begin
                repeat (171) tick();
                rx_ready = 1'b1;
                tick();
                rx_ready = 1'b0;
                check("same_cyc_data", rx_data, 8'h55);
                check("same_cyc_valid", rx_valid, 1);
                check("same_cyc_ovr", rx_overrun, 0);
            end
        join
        repeat (5) tick();

        // Reset on the 4th shift (t + 72 = start + 74), word 0x55 still held
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                repeat (74) tick();
                rx_rst_n = 1'b0;
                #1;
                check("rst_cycle_shift", shift, 0);
                tick();
                rx_rst_n = 1'b1;
                check("midrst_sync", rx_sync, 1);
                check("midrst_busy", busy, 0);
                check("midrst_strobes", {shift, parity_load, check_stop}, 0);
                check("midrst_valid", rx_valid, 0);
                check("midrst_data", rx_data, 0);
                check("midrst_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 0);
            end
        join
        repeat (5) tick();
        check("midrst_no_frame", rx_valid, 0);
        send_frame(8'h0F, 1'b0, 1'b0);
        wait_valid("post_rst_valid");
        check("post_rst_data", rx_data, 8'h0F);
        check("post_rst_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 0);
        pulse_ready();
        repeat (5) tick();

        // Randomized frames against a scoreboard of sent words
        send_done = 1'b0;
        n_extra   = 0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    exp_t e;
                    int gap;
                    e.d  = 8'($urandom);
                    e.pe = ($urandom_range(0, 3) == 0);
                    e.fe = ($urandom_range(0, 3) == 0);
                    exp_q.push_back(e);
                    send_frame(e.d, e.pe, e.fe);
                    gap = $urandom_range(0, 20);
                    if (e.fe) begin
                        repeat ($urandom_range(0, 30)) tick();
                        rx_in = 1'b1;
                        gap += 2;
                    end
                    repeat (gap) tick();
                end
                send_done = 1'b1;
            end
            begin
                int held = 0;
                int guard = 0;
                while (!(send_done && exp_q.size() == 0) && guard < 20000) begin
                    held = rx_valid ? held + 1 : 0;
                    rx_ready = (held > 30) || ($urandom_range(0, 3) == 0);
                    if (rx_valid && rx_ready) begin
                        if (exp_q.size() == 0) begin
                            n_extra++;
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            check("rand_data", rx_data, e.d);
                            check("rand_perr", rx_parity_err, e.pe);
                            check("rand_ferr", rx_frame_err, e.fe);
                        end
                    end
                    tick();
                    guard++;
                end
                rx_ready = 1'b0;
            end
        join
        repeat (5) tick();
        check("rand_drained", exp_q.size(), 0);
        check("rand_extra", n_extra, 0);
        check("rand_overrun", rx_overrun, 0);
        check("strobe_overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
